// File: rtl/usb_tx_packetizer.sv
// USB DATA packet builder: PID, payload popped from a FWFT FIFO, then inverted CRC16 (low byte first).
// Runs in the FIFO read-clock domain and hands one byte at a time to the serializer.
module usb_tx_packetizer #(
    parameter int DATASIZE = 8,
    parameter int LENW     = 11
) (
    input  logic                read_clk,
    input  logic                read_rst,
    input  logic                start,
    input  logic [3:0]          pid,
    input  logic [LENW-1:0]     len,
    input  logic                empty,
    input  logic [DATASIZE-1:0] read_data,
    output logic                read_enable,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic                underrun,
    output logic                done,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [LENW-1:0] count, count_d;
    logic [15:0]     crc, crc_d;
    logic [7:0]      data_d;
    logic            valid_d, last_d, done_d;
    logic            slot_free;

    // CRC-16/USB, reflected polynomial 0xA001, one whole byte per call, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Output handshake: a byte transfers on any edge where tx_valid && tx_ready;
    // while tx_valid && !tx_ready the slot (tx_data, tx_last) and the state hold still.
    assign slot_free = !tx_valid || tx_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge read_clk) begin
        if (!read_rst) begin
            state    <= S_IDLE;
            count    <= '0;
            crc      <= 16'hFFFF;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            crc      <= crc_d;
            tx_data  <= data_d;
            tx_valid <= valid_d;
            tx_last  <= last_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        count_d     = count;
        crc_d       = crc;
        data_d      = tx_data;
        valid_d     = tx_valid;
        last_d      = tx_last;
        done_d      = 1'b0;
        read_enable = 1'b0;
        underrun    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    count_d = len;
                    crc_d   = 16'hFFFF;
                    data_d  = {~pid, pid};
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_PID;
                end
            end

            // PID and DATA both load the next byte as soon as the slot frees up.
            S_PID, S_DATA: begin
                if (slot_free) begin
                    if (count == '0) begin
                        // Empty payload: CRC low follows the PID directly, so CRC high is next.
                        data_d  = ~crc[7:0];
                        valid_d = 1'b1;
                        state_d = S_CRC_HI;
                    end else if (!empty) begin
                        read_enable = read_rst;
                        data_d      = read_data[7:0];
                        valid_d     = 1'b1;
                        crc_d       = crc16_byte(crc, read_data[7:0]);
                        count_d     = count - LENW'(1);
                        state_d     = (count == LENW'(1)) ? S_CRC_LO : S_DATA;
                    end else begin
                        valid_d  = 1'b0;
                        underrun = (state == S_DATA);
                        state_d  = S_DATA;
                    end
                end
            end

            S_CRC_LO: begin
                if (slot_free) begin
                    data_d  = ~crc[7:0];
                    valid_d = 1'b1;
                    state_d = S_CRC_HI;
                end
            end

            S_CRC_HI: begin
                if (slot_free) begin
                    if (tx_valid && tx_last) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        data_d  = ~crc[15:8];
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    a_no_pop_empty: assert property (@(posedge read_clk) disable iff (!read_rst)
        !(read_enable && empty));

    a_hold_slot: assert property (@(posedge read_clk) disable iff (!read_rst)
        (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data) && $stable(tx_last)));

endmodule
